// File: rtl/serial_feeder_pkg.sv
// Shared types and default parameters for the serial word feeder.
package serial_feeder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 5;
   localparam int unsigned DEFAULT_GAP   = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } feeder_state_t;

endpackage : serial_feeder_pkg

// File: rtl/bit_counter.sv
// Mod-N up-counter with synchronous clear and a terminal-count flag.
module bit_counter #(
   parameter int unsigned N = 5,
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          en,
   output logic [CW-1:0] count,
   output logic          tc_c
);

   // Terminal count: the counter sits on its last value.
   assign tc_c = (count == CW'(N - 1));

   // Count register: clear wins over enable; wraps to zero after N-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (en) begin
         count <= tc_c ? '0 : count + CW'(1);
      end
   end

endmodule : bit_counter

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial word feeder: MSB first, one holding buffer, optional idle gap between words.
module serial_word_feeder
   import serial_feeder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned GAP   = DEFAULT_GAP
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int unsigned BIT_CW = $clog2(WIDTH);
   localparam int unsigned GAP_N  = (GAP > 0) ? GAP : 1;
   localparam int unsigned GAP_CW = (GAP_N > 1) ? $clog2(GAP_N) : 1;

   feeder_state_t state, state_next;
   logic [WIDTH-1:0] shreg, shreg_next;
   logic [WIDTH-1:0] hold_buf, hold_buf_next;
   logic             buf_full, buf_full_next;

   logic              bit_clr, bit_en, bit_tc;
   logic              gap_clr, gap_en, gap_tc;
   logic [BIT_CW-1:0] bit_cnt;
   logic [GAP_CW-1:0] gap_cnt_unused;
   logic              transfer;

   // A word is taken only on a valid/ready handshake.
   assign transfer = data_valid && data_ready;

   bit_counter #(.N(WIDTH)) u_bit_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (bit_clr),
      .en      (bit_en),
      .count   (bit_cnt),
      .tc_c    (bit_tc)
   );

   // Only the terminal count of the gap timer matters; its value is unused.
   bit_counter #(.N(GAP_N)) u_gap_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (gap_clr),
      .en      (gap_en),
      .count   (gap_cnt_unused),
      .tc_c    (gap_tc)
   );

   // Next-state, shift-register and holding-buffer control.
   always_comb begin
      state_next    = state;
      shreg_next    = shreg;
      hold_buf_next = hold_buf;
      buf_full_next = buf_full;
      bit_clr       = 1'b0;
      bit_en        = 1'b0;
      gap_clr       = 1'b0;
      gap_en        = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (transfer) begin
               shreg_next = data_in;
               bit_clr    = 1'b1;
               state_next = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            bit_en     = 1'b1;
            shreg_next = shreg << 1;
            if (!bit_tc) begin
               if (transfer) begin
                  hold_buf_next = data_in;
                  buf_full_next = 1'b1;
               end
            end else if (GAP > 0) begin
               state_next = ST_GAP;
               gap_clr    = 1'b1;
               if (transfer) begin
                  hold_buf_next = data_in;
                  buf_full_next = 1'b1;
               end
            end else if (buf_full) begin
               // data_ready was low, so no transfer can collide with the drain
               shreg_next    = hold_buf;
               buf_full_next = 1'b0;
               bit_clr       = 1'b1;
            end else if (transfer) begin
               // same-edge handoff straight into the shifter, no bubble
               shreg_next = data_in;
               bit_clr    = 1'b1;
            end else begin
               state_next = ST_IDLE;
            end
         end

         ST_GAP: begin
            gap_en = 1'b1;
            if (!gap_tc) begin
               if (transfer) begin
                  hold_buf_next = data_in;
                  buf_full_next = 1'b1;
               end
            end else if (buf_full) begin
               shreg_next    = hold_buf;
               buf_full_next = 1'b0;
               bit_clr       = 1'b1;
               state_next    = ST_SHIFT;
            end else if (transfer) begin
               shreg_next = data_in;
               bit_clr    = 1'b1;
               state_next = ST_SHIFT;
            end else begin
               state_next = ST_IDLE;
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State, active word and holding buffer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         shreg    <= '0;
         hold_buf <= '0;
         buf_full <= 1'b0;
      end else begin
         state    <= state_next;
         shreg    <= shreg_next;
         hold_buf <= hold_buf_next;
         buf_full <= buf_full_next;
      end
   end

   // Registered outputs, computed from next-state values so they align with the state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_ready   <= 1'b0;
         serial_out   <= 1'b0;
         serial_valid <= 1'b0;
         word_done    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         data_ready   <= !buf_full_next;
         serial_valid <= (state_next == ST_SHIFT);
         serial_out   <= (state_next == ST_SHIFT) && shreg_next[WIDTH-1];
         word_done    <= (state == ST_SHIFT) && (bit_cnt == BIT_CW'(WIDTH - 2));
         busy         <= (state_next != ST_IDLE) || buf_full_next;
      end
   end

endmodule : serial_word_feeder

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: two instances (gap 0 and gap 3) against a word-level reference model.
module tb_serial_word_feeder;

   localparam int unsigned W     = 5;
   localparam int unsigned GAP_A = 0;
   localparam int unsigned GAP_B = 3;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           dv    [2];
   logic [W-1:0]   din   [2];
   logic           rdy   [2];
   logic           sout  [2];
   logic           sval  [2];
   logic           wdone [2];
   logic           bsy   [2];

   always #5 clk = ~clk;

   serial_word_feeder #(.WIDTH(W), .GAP(GAP_A)) dut_a (
      .clk(clk), .reset_n(reset_n), .data_in(din[0]), .data_valid(dv[0]),
      .data_ready(rdy[0]), .serial_out(sout[0]), .serial_valid(sval[0]),
      .word_done(wdone[0]), .busy(bsy[0])
   );

   serial_word_feeder #(.WIDTH(W), .GAP(GAP_B)) dut_b (
      .clk(clk), .reset_n(reset_n), .data_in(din[1]), .data_valid(dv[1]),
      .data_ready(rdy[1]), .serial_out(sout[1]), .serial_valid(sval[1]),
      .word_done(wdone[1]), .busy(bsy[1])
   );

   int checks   = 0;
   int failures = 0;

   // reference model: active word + bit index, remaining gap cycles, pending word
   bit           m_act  [2];
   logic [W-1:0] m_word [2];
   int           m_bit  [2];
   int           m_gap  [2];
   bit           m_pv   [2];
   logic [W-1:0] m_pw   [2];
   bit           m_live;

   // stimulus source
   logic [W-1:0] words [$];
   int           src_idx [2];
   int           vmode;

   // output monitor
   logic [W-1:0] got_a [$];
   logic [W-1:0] got_b [$];
   logic [W-1:0] col   [2];
   int           ncol  [2];
   logic [63:0]  sbits [2];
   int           nbits [2];
   int           runs  [2];
   int           zcnt  [2];
   int           last_gap [2];
   bit           prevv [2];

   function automatic string nm(input int k);
      return (k == 0) ? "gap0" : "gap3";
   endfunction

   function automatic int gap_of(input int k);
      return (k == 0) ? int'(GAP_A) : int'(GAP_B);
   endfunction

   function automatic logic exp_out(input int k);
      if (!m_act[k]) return 1'b0;
      return m_word[k][int'(W) - 1 - m_bit[k]];
   endfunction

   function automatic logic exp_done(input int k);
      return m_act[k] && (m_bit[k] == int'(W) - 1);
   endfunction

   function automatic logic exp_ready(input int k);
      return m_live && !m_pv[k];
   endfunction

   function automatic logic exp_busy(input int k);
      return m_act[k] || (m_gap[k] > 0) || m_pv[k];
   endfunction

   function automatic bit model_idle(input int k);
      return !m_act[k] && (m_gap[k] == 0) && !m_pv[k];
   endfunction

   function automatic bit all_done();
      return (src_idx[0] == words.size()) && (src_idx[1] == words.size()) &&
             model_idle(0) && model_idle(1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_act[k] = 1'b0; m_word[k] = '0; m_bit[k] = 0;
         m_gap[k] = 0;    m_pv[k]   = 1'b0; m_pw[k] = '0;
         col[k]   = '0;   ncol[k]   = 0;
      end
      m_live = 1'b0;
   endtask

   // one clock edge of the reference model; t = handshake seen at that edge
   task automatic model_edge(input int k, input bit t, input logic [W-1:0] d);
      if (m_act[k]) begin
         if (m_bit[k] == int'(W) - 1) begin
            m_act[k] = 1'b0;
            if (gap_of(k) > 0) begin
               m_gap[k] = gap_of(k);
               if (t) begin m_pv[k] = 1'b1; m_pw[k] = d; end
            end else if (m_pv[k]) begin
               m_act[k] = 1'b1; m_word[k] = m_pw[k]; m_bit[k] = 0; m_pv[k] = 1'b0;
            end else if (t) begin
               m_act[k] = 1'b1; m_word[k] = d; m_bit[k] = 0;
            end
         end else begin
            m_bit[k]++;
            if (t) begin m_pv[k] = 1'b1; m_pw[k] = d; end
         end
      end else if (m_gap[k] > 0) begin
         m_gap[k]--;
         if (m_gap[k] == 0) begin
            if (m_pv[k]) begin
               m_act[k] = 1'b1; m_word[k] = m_pw[k]; m_bit[k] = 0; m_pv[k] = 1'b0;
            end else if (t) begin
               m_act[k] = 1'b1; m_word[k] = d; m_bit[k] = 0;
            end
         end else if (t) begin
            m_pv[k] = 1'b1; m_pw[k] = d;
         end
      end else if (t) begin
         m_act[k] = 1'b1; m_word[k] = d; m_bit[k] = 0;
      end
   endtask

   task automatic check_outputs(input int k);
      chk({nm(k), ".serial_out"},   32'(sout[k]),  32'(exp_out(k)));
      chk({nm(k), ".serial_valid"}, 32'(sval[k]),  32'(m_act[k]));
      chk({nm(k), ".word_done"},    32'(wdone[k]), 32'(exp_done(k)));
      chk({nm(k), ".data_ready"},   32'(rdy[k]),   32'(exp_ready(k)));
      chk({nm(k), ".busy"},         32'(bsy[k]),   32'(exp_busy(k)));
   endtask

   task automatic monitor(input int k);
      if (sval[k] === 1'b1) begin
         sbits[k] = {sbits[k][62:0], sout[k]};
         nbits[k]++;
         col[k] = {col[k][W-2:0], sout[k]};
         ncol[k]++;
         if (ncol[k] == int'(W)) begin
            if (k == 0) got_a.push_back(col[k]);
            else        got_b.push_back(col[k]);
            ncol[k] = 0;
         end
         if (!prevv[k]) begin
            runs[k]++;
            if (runs[k] > 1) last_gap[k] = zcnt[k];
         end
         zcnt[k]  = 0;
         prevv[k] = 1'b1;
      end else begin
         zcnt[k]++;
         prevv[k] = 1'b0;
      end
   endtask

   // one full clock: check at negedge, drive inputs, advance model at posedge
   task automatic cycle();
      bit t [2];
      bit offer;
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         monitor(k);
         check_outputs(k);
      end
      for (int k = 0; k < 2; k++) begin
         offer = src_idx[k] < words.size();
         if (vmode == 1)      offer = offer && ($urandom_range(0, 1) == 1);
         else if (vmode == 2) offer = offer && (model_idle(k) || exp_done(k));
         dv[k]  = offer;
         din[k] = offer ? words[src_idx[k]] : W'($urandom);
         t[k]   = offer && exp_ready(k);
      end
      @(posedge clk);
      if (reset_n) begin
         for (int k = 0; k < 2; k++) begin
            model_edge(k, t[k], din[k]);
            if (t[k]) src_idx[k]++;
         end
      end
   endtask

   task automatic release_reset();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check_outputs(k);
         dv[k] = 1'b0;
      end
      reset_n = 1'b1;
      @(posedge clk);
      m_live = 1'b1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (!all_done() && n < budget) begin
         cycle();
         n++;
      end
      chk("drain_complete", 32'(all_done()), 32'd1);
      cycle();
   endtask

   task automatic begin_scn();
      words.delete();
      got_a.delete();
      got_b.delete();
      for (int k = 0; k < 2; k++) begin
         src_idx[k] = 0; col[k] = '0; ncol[k] = 0; sbits[k] = '0; nbits[k] = 0;
         runs[k] = 0; zcnt[k] = 0; last_gap[k] = -1; prevv[k] = 1'b0;
      end
   endtask

   task automatic check_words(input int k);
      int n = (k == 0) ? got_a.size() : got_b.size();
      chk({nm(k), ".word_count"}, 32'(n), 32'(words.size()));
      for (int i = 0; i < n && i < words.size(); i++) begin
         chk($sformatf("%s.word[%0d]", nm(k), i),
             32'((k == 0) ? got_a[i] : got_b[i]), 32'(words[i]));
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      for (int k = 0; k < 2; k++) begin dv[k] = 1'b0; din[k] = '0; end
      model_reset();
      vmode = 0;
      begin_scn();

      // held in reset: everything low, not ready
      cycle();
      cycle();
      release_reset();

      // single word, MSB first, done on the fifth bit
      begin_scn();
      words.push_back(5'b10100);
      drain(50);
      check_words(0);
      check_words(1);
      chk("gap0.pattern_match", 32'(sbits[0][4:0]), 32'(5'b10100));
      chk("gap0.bit_count", 32'(nbits[0]), 32'd5);

      // two words with valid held: contiguous at gap 0, three idle cycles at gap 3
      begin_scn();
      words.push_back(5'b11001);
      words.push_back(5'b00111);
      drain(60);
      check_words(0);
      check_words(1);
      chk("gap0.stream10", 32'(sbits[0][9:0]), 32'(10'b1100100111));
      chk("gap0.valid_runs", 32'(runs[0]), 32'd1);
      chk("gap3.valid_runs", 32'(runs[1]), 32'd2);
      chk("gap3.idle_between", 32'(last_gap[1]), 32'd3);

      // third word offered with buffer full: back-pressured, order kept
      begin_scn();
      words.push_back(5'b10011);
      words.push_back(5'b01010);
      words.push_back(5'b11100);
      drain(80);
      check_words(0);
      check_words(1);
      chk("gap0.bits15", 32'(nbits[0]), 32'd15);
      chk("gap0.valid_runs3", 32'(runs[0]), 32'd1);
      chk("gap3.idle_between3", 32'(last_gap[1]), 32'd3);

      // second word offered only in the word_done cycle: no bubble at gap 0
      begin_scn();
      vmode = 2;
      words.push_back(5'b01101);
      words.push_back(5'b10010);
      drain(60);
      check_words(0);
      check_words(1);
      chk("gap0.handoff_runs", 32'(runs[0]), 32'd1);
      chk("gap0.handoff_stream", 32'(sbits[0][9:0]), 32'(10'b0110110010));

      // asynchronous reset mid-word
      begin_scn();
      vmode = 0;
      words.push_back(5'b10110);
      for (int n = 0; n < 20 && nbits[0] < 2; n++) cycle();
      #2 reset_n = 1'b0;
      #1 model_reset();
      check_outputs(0);
      check_outputs(1);
      cycle();
      cycle();
      release_reset();
      repeat (6) cycle();
      chk("gap0.bits_after_reset", 32'(nbits[0]), 32'd2);
      chk("gap3.bits_after_reset", 32'(nbits[1]), 32'd2);
      chk("gap0.partial_bits", 32'(sbits[0][1:0]), 32'(2'b10));
      chk("gap0.no_word_after_reset", 32'(got_a.size()), 32'd0);
      chk("gap3.no_word_after_reset", 32'(got_b.size()), 32'd0);

      // random words with random valid gaps
      begin_scn();
      vmode = 1;
      for (int i = 0; i < 40; i++) words.push_back(W'($urandom));
      drain(3000);
      check_words(0);
      check_words(1);

      // random words offered at word boundaries
      begin_scn();
      vmode = 2;
      for (int i = 0; i < 15; i++) words.push_back(W'($urandom));
      drain(1500);
      check_words(0);
      check_words(1);
      chk("gap0.boundary_runs", 32'(runs[0]), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_word_feeder

// File: doc/serial_word_feeder.md
SERIAL_WORD_FEEDER -- requirements
Module: serial_word_feeder

Interface
REQ-001 Parameter WIDTH, default 5, word width in bits (range 2..16).
REQ-002 Parameter GAP, default 0, idle cycles inserted between consecutive words (range 0..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  WIDTH  parallel word to serialize, MSB sent first.
REQ-006 data_valid  input  1  producer asserts when data_in holds a word.
REQ-007 data_ready  output  1  feeder can accept a word this cycle.
REQ-008 serial_out  output  1  serial bit stream; drives serial_in of pattern_detection.
REQ-009 serial_valid  output  1  serial_out carries a payload bit this cycle.
REQ-010 word_done  output  1  one-cycle pulse coincident with the last bit of each word.
REQ-011 busy  output  1  high whenever state is not IDLE or the holding buffer is full.

Function
REQ-012 Transfer occurs at a rising edge where data_valid && data_ready; no other condition loads a word.
REQ-013 Storage: one shift register (active word) plus one holding buffer (next word); data_ready = !buf_full.
REQ-014 FSM states IDLE, SHIFT, GAP; encoding via shared enum.
REQ-015 IDLE + transfer at edge k: word goes directly to the shift register, state -> SHIFT; serial_out = data_in[WIDTH-1], serial_valid = 1 in the cycle after edge k (latency 1).
REQ-016 SHIFT: shift register moves left one bit per edge; bit counter counts 0..WIDTH-1; serial_valid = 1.
REQ-017 word_done = 1 exactly when state is SHIFT and the bit counter = WIDTH-1.
REQ-018 A transfer while state is SHIFT or GAP stores the word in the holding buffer; buf_full -> 1.
REQ-019 End of word (last-bit edge), GAP = 0, buf_full: buffer moves to the shift register, counter -> 0, state stays SHIFT; no idle cycle between words.
REQ-020 End of word, GAP > 0: state -> GAP for exactly GAP cycles with serial_valid = 0 and serial_out = 0.
REQ-021 End of GAP, buf_full: buffer moves to the shift register, state -> SHIFT.
REQ-022 End of word (GAP = 0) or end of GAP, buffer empty: state -> IDLE.
REQ-023 A transfer on the same edge that ends a word (REQ-022 case) loads the shift register directly: back-to-back, no bubble.
REQ-024 The buffer drains on an edge where data_ready was 0, so a drain and a buffer write never coincide; the buffer is never overwritten.
REQ-025 In IDLE: serial_out = 0, serial_valid = 0, word_done = 0.
REQ-026 Changes on data_in or data_valid without a transfer have no effect.

Reset
REQ-027 reset_n low asynchronously forces state IDLE, counters 0, shift register 0, buffer empty.
REQ-028 Reset outputs: serial_out = 0, serial_valid = 0, word_done = 0, busy = 0.
REQ-029 data_ready = 0 while reset_n is low; data_ready = 1 from the first cycle after release.
REQ-030 Reset mid-word discards the active word and the buffered word; no partial bits are emitted after release.

Structure
REQ-031 Package serial_feeder_pkg holds the state enum typedef and the default WIDTH/GAP constants.
REQ-032 Sub-module bit_counter, a parameterized mod-N up-counter with clear and terminal-count output, is used for both the bit count and the gap count.

Verification
REQ-033 WIDTH = 5, one word 5'b10100 -> serial_out 1,0,1,0,0 on five consecutive cycles starting 1 cycle after transfer; word_done on the 5th bit; downstream pattern_detection loaded with 5'b10100 asserts pattern_match.
REQ-034 Words 5'b11001 then 5'b00111, data_valid held, GAP = 0 -> 10 contiguous valid bits 1100100111; data_ready low while buffer full; no bubble.
REQ-035 GAP = 3, two words -> exactly 3 cycles of serial_valid = 0 between the last bit of word 1 and the first bit of word 2.
REQ-036 Third word offered while shifting with buffer full -> data_ready = 0, word not accepted, no data loss, order preserved.
REQ-037 reset_n pulsed low at bit 3 of 5'b10110 -> outputs zero immediately (asynchronous); after release IDLE, data_ready = 1, no residual bits.
REQ-038 data_valid pulse coinciding with word_done, buffer empty, GAP = 0 -> new word's MSB emitted on the next cycle.
